// File: rtl/uart_console_pkg.sv
// Shared definitions for the uart_console Wishbone console slave:
// transmit FSM encoding and 8N1 frame geometry.
package uart_console_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_console_fifo.sv
// Synchronous FIFO between the Wishbone write port and the UART transmitter.
// Read data is the word at the read pointer; a pop advances past it.
module uart_console_fifo
    import uart_console_pkg::*;
#(
    parameter int WIDTH = UART_DATA_BITS,
    parameter int AW    = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (o_count == DEPTH);
    assign o_empty = (o_count == '0);
    assign do_push = i_push && !full;
    assign do_pop  = i_pop && !o_empty;
    assign o_data  = mem[rd_ptr];

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   o_count <= o_count + 1'b1;
                2'b01:   o_count <= o_count - 1'b1;
                default: o_count <= o_count;
            endcase
        end
    end

    // NOTE: storage is not reset; count and pointers alone define what is valid.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= i_data;
    end

endmodule

// File: rtl/uart_console.sv
// Wishbone write-only console: bytes are queued in a FIFO and sent as 8N1 UART frames.
// Define UART_CONSOLE_SIM_PRINT_EN to echo every accepted byte to the simulator log.
module uart_console
    import uart_console_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_AW      = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_stb,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic        o_uart_tx,
    output logic        o_tx_busy
);

    localparam int                BAUD_W      = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]  FIFO_DEPTH  = (FIFO_AW+1)'(2**FIFO_AW);
    localparam logic [2:0]        LAST_BIT    = 3'(UART_DATA_BITS - 1);

    tx_state_e         state;
    tx_state_e         state_next;
    logic [BAUD_W-1:0] baud;
    logic [BAUD_W-1:0] baud_next;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_idx_next;
    logic [7:0]        shift;
    logic [7:0]        shift_next;
    logic              tx_next;
    logic              pop;
    logic              accept;
    logic              fifo_empty;
    logic [FIFO_AW:0]  fifo_count;
    logic [7:0]        fifo_rdata;
    logic              unused_ok;

    assign unused_ok  = &{1'b0, i_wb_data[31:8]};
    assign o_wb_stall = (fifo_count == FIFO_DEPTH);
    assign accept     = i_wb_stb && !o_wb_stall;
    assign o_tx_busy  = !fifo_empty || (state != ST_IDLE);

    uart_console_fifo #(
        .WIDTH (UART_DATA_BITS),
        .AW    (FIFO_AW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (accept),
        .i_data  (i_wb_data[7:0]),
        .i_pop   (pop),
        .o_data  (fifo_rdata),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) o_wb_ack <= 1'b0;
        else         o_wb_ack <= accept;
    end

    // NOTE: every output gets a default first, so no path infers a latch.
    always_comb begin
        state_next   = state;
        baud_next    = baud;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        tx_next      = o_uart_tx;
        pop          = 1'b0;

        case (state)
            ST_IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_rdata;
                    tx_next    = 1'b0;
                    baud_next  = BAUD_RELOAD;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (baud == '0) begin
                    baud_next    = BAUD_RELOAD;
                    tx_next      = shift[0];
                    shift_next   = shift >> 1;
                    bit_idx_next = '0;
                    state_next   = ST_DATA;
                end else begin
                    baud_next = baud - 1'b1;
                end
            end
            ST_DATA: begin
                if (baud == '0) begin
                    baud_next = BAUD_RELOAD;
                    if (bit_idx == LAST_BIT) begin
                        tx_next    = 1'b1;
                        state_next = ST_STOP;
                    end else begin
                        tx_next      = shift[0];
                        shift_next   = shift >> 1;
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end else begin
                    baud_next = baud - 1'b1;
                end
            end
            ST_STOP: begin
                if (baud == '0) begin
                    // Chain straight into the next start bit when more bytes wait.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_rdata;
                        tx_next    = 1'b0;
                        baud_next  = BAUD_RELOAD;
                        state_next = ST_START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end else begin
                    baud_next = baud - 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            baud      <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            o_uart_tx <= 1'b1;
        end else begin
            state     <= state_next;
            baud      <= baud_next;
            bit_idx   <= bit_idx_next;
            shift     <= shift_next;
            o_uart_tx <= tx_next;
        end
    end

`ifdef UART_CONSOLE_SIM_PRINT_EN
    always_ff @(posedge i_clk) begin
        if (!i_reset && accept) $write("%c", i_wb_data[7:0]);
    end
`else
    // Console text only reaches the serial line.
`endif

endmodule

// File: tb/tb_uart_console.sv
// Directed self-checking bench for uart_console with CLKS_PER_BIT=4, FIFO_AW=4.
// Cycle 0 of each scenario is the cycle in which the first strobe is presented.
module tb_uart_console;
    import uart_console_pkg::*;

    localparam int CPB   = 4;
    localparam int AW    = 4;
    localparam int FRAME = UART_FRAME_BITS * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic [31:0] data;
    logic        ack;
    logic        stall;
    logic        tx;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_console #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (AW)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_wb_stb   (stb),
        .i_wb_data  (data),
        .o_wb_ack   (ack),
        .o_wb_stall (stall),
        .o_uart_tx  (tx),
        .o_tx_busy  (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line level for bit position idx of an 8N1 frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[3'(idx - 1)];
    endfunction

    // Called in the first start-bit cycle; checks the line for all frames back to back.
    task automatic check_frames(input string tag, input logic [7:0] bytes [$]);
        for (int k = 0; k < bytes.size(); k++) begin
            for (int j = 0; j < FRAME; j++) begin
                check(tag, 32'(tx), 32'(frame_bit(bytes[k], j / CPB)));
                tick();
            end
        end
    endtask

    initial begin
        logic [7:0] q [$];
        int         nacc;
        logic       prev_acc;
        logic       exp_stall;
        int         last_cycle;

        rst  = 1'b1;
        stb  = 1'b0;
        data = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // Single write 0x41; upper data bits must be ignored.
        stb  = 1'b1;
        data = 32'hDEAD_BE41;
        check("single_ack_c0", 32'(ack), 32'd0);
        tick();
        stb = 1'b0;
        check("single_ack_c1", 32'(ack), 32'd1);
        check("single_tx_c1", 32'(tx), 32'd1);
        check("single_busy_c1", 32'(busy), 32'd1);
        tick();
        check("single_ack_c2", 32'(ack), 32'd0);
        q = '{8'h41};
        check_frames("single_frame", q);
        check("single_busy_c42", 32'(busy), 32'd0);
        check("single_tx_c42", 32'(tx), 32'd1);

        // Two back-to-back writes: 80 contiguous frame cycles.
        stb  = 1'b1;
        data = 32'h55;
        tick();
        data = 32'hAA;
        check("b2b_ack_c1", 32'(ack), 32'd1);
        tick();
        stb = 1'b0;
        check("b2b_ack_c2", 32'(ack), 32'd1);
        q = '{8'h55, 8'hAA};
        check_frames("b2b_frames", q);
        check("b2b_busy_end", 32'(busy), 32'd0);

        // Fill: strobe held with incrementing data through cycle 42.
        nacc       = 0;
        prev_acc   = 1'b0;
        last_cycle = 2 + 18 * FRAME;
        for (int c = 0; c < last_cycle; c++) begin
            if (c <= 42) begin
                stb       = 1'b1;
                data      = 32'(nacc);
                exp_stall = (c >= 17) && (c <= 41);
                check("fill_stall", 32'(stall), 32'(exp_stall));
            end else begin
                stb       = 1'b0;
                exp_stall = 1'b1;
            end
            if (c <= 43) check("fill_ack", 32'(ack), 32'(prev_acc));
            if (c < 2) check("fill_tx_idle", 32'(tx), 32'd1);
            else check("fill_tx", 32'(tx),
                       32'(frame_bit(8'((c - 2) / FRAME), ((c - 2) % FRAME) / CPB)));
            prev_acc = (c <= 42) && !exp_stall;
            if (prev_acc) nacc++;
            tick();
        end
        check("fill_busy_end", 32'(busy), 32'd0);
        check("fill_tx_end", 32'(tx), 32'd1);

        // Reset in the middle of the data bits of 0x0F with three bytes queued.
        for (int c = 0; c < 14; c++) begin
            stb  = (c < 4);
            data = (c == 0) ? 32'h0F : 32'(c);
            tick();
        end
        check("rst_mid_tx_before", 32'(tx), 32'(frame_bit(8'h0F, 3)));
        check("rst_mid_busy_before", 32'(busy), 32'd1);
        rst  = 1'b1;
        stb  = 1'b1;
        data = 32'h77;
        tick();
        rst = 1'b0;
        stb = 1'b0;
        check("rst_mid_tx", 32'(tx), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ack", 32'(ack), 32'd0);
        check("rst_mid_stall", 32'(stall), 32'd0);
        for (int c = 0; c < 3 * FRAME; c++) begin
            tick();
            check("rst_mid_quiet_tx", 32'(tx), 32'd1);
            check("rst_mid_quiet_busy", 32'(busy), 32'd0);
        end
        check("rst_mid_quiet_ack", 32'(ack), 32'd0);

        // "Hi" on the serial line.
        stb  = 1'b1;
        data = 32'h48;
        tick();
        data = 32'h69;
        tick();
        stb = 1'b0;
        q = '{8'h48, 8'h69};
        check_frames("hi_frames", q);
        check("hi_busy_end", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
